// File: rtl/key_cond_pkg.sv
// -----------------------------------------------------------------------------
// key_cond_pkg
// Shared types and elaboration-time helpers for the key conditioner.
//   key_state_t   : per-key FSM state (IDLE, PRESS_DB, HELD, RELEASE_DB)
//   ms_to_cycles  : converts a duration in ms to clock cycles
//   max_int       : larger of two integers
//   cnt_width     : bits needed to hold values 0..max_val (clog2(max_val+1), min 1)
// -----------------------------------------------------------------------------
package key_cond_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } key_state_t;

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while (w < 31 && (1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// -----------------------------------------------------------------------------
// key_debounce_fsm
// Conditions one active-low push-button: two-flop synchronizer, debounce FSM,
// hold counter, registered level and single-cycle event strobes.
// Optional feature: define KEY_AUTOREPEAT_EN to re-fire press_o every REP_CYC
// cycles after the long-press strobe while the key stays held.
//
// Ports
//   clk_i      in   clock
//   rst_i      in   synchronous active-high reset
//   key_n_i    in   raw key, active-low, asynchronous
//   level_o    out  debounced level, 1 = pressed
//   press_o    out  1-cycle strobe on accepted press (and repeats)
//   release_o  out  1-cycle strobe on accepted release
//   long_o     out  1-cycle strobe when hold time reaches LONG_CYC
//   state_o    out  current FSM state, for debug visibility
// -----------------------------------------------------------------------------
module key_debounce_fsm
    import key_cond_pkg::*;
#(
    parameter int DEB_CYC  = 4,
    parameter int LONG_CYC = 20,
    parameter int REP_CYC  = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       key_n_i,
    output logic       level_o,
    output logic       press_o,
    output logic       release_o,
    output logic       long_o,
    output key_state_t state_o
);

    localparam int DEB_W  = cnt_width(DEB_CYC);
    localparam int HOLD_W = cnt_width(max_int(LONG_CYC, REP_CYC));

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REP_CYC - 1);
`else
    localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;
`endif

    // Synchronizer stores the pressed polarity; reset to "released".
    logic sync1_q;
    logic sync2_q;
    logic s;

    key_state_t        state_q, state_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_done_q, long_done_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;

    assign s = sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= IDLE;
            deb_q       <= '0;
            hold_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync1_q     <= ~key_n_i;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            deb_q       <= deb_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        deb_d       = deb_q;
        hold_d      = hold_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        level_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_DB;
                    deb_d   = '0;
                end
            end

            PRESS_DB: begin
                if (!s) begin
                    state_d = IDLE;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    state_d     = HELD;
                    press_d     = 1'b1;
                    hold_d      = '0;
                    long_done_d = 1'b0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end

            HELD: begin
                if (!s) begin
                    // Hold counter freezes for the whole release debounce.
                    state_d = RELEASE_DB;
                    deb_d   = '0;
                end else if (!long_done_q) begin
                    hold_d = hold_q + 1'b1;
                    if (hold_q == LONG_LAST) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                        // Counter is reused to time the repeat period.
                        hold_d      = '0;
`endif
                    end
                end else begin
`ifdef KEY_AUTOREPEAT_EN
                    if (hold_q == REP_LAST) begin
                        press_d = 1'b1;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
`else
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end
`endif
                end
            end

            RELEASE_DB: begin
                if (s) begin
                    state_d = HELD;
                end else if (deb_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    deb_d     = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        level_d = (state_d == HELD) || (state_d == RELEASE_DB);
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign state_o   = state_q;

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
// Synchronizes and debounces NKEYS active-low push-buttons, producing a clean
// pressed level and single-cycle press / release / long-press strobes.
// Keys are processed fully independently by one key_debounce_fsm each.
// Optional feature: define KEY_AUTOREPEAT_EN for press auto-repeat after a
// long press (period REPEAT_MS).
//
// Ports
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   key            in   [NKEYS] raw buttons, active-low, asynchronous
//   key_level      out  [NKEYS] debounced level, 1 = pressed
//   press_pulse    out  [NKEYS] strobe on accepted press (and repeats)
//   release_pulse  out  [NKEYS] strobe on accepted release
//   long_pulse     out  [NKEYS] strobe when hold time reaches LONG_MS
// -----------------------------------------------------------------------------
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int NKEYS       = 2,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] key,
    output logic [NKEYS-1:0] key_level,
    output logic [NKEYS-1:0] press_pulse,
    output logic [NKEYS-1:0] release_pulse,
    output logic [NKEYS-1:0] long_pulse
);

    localparam int DEB_CYC  = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);
    localparam int REP_CYC  = ms_to_cycles(CLK_HZ, REPEAT_MS);

    // Per-key FSM state, kept visible for debug probes.
    key_state_t key_state_unused [NKEYS];

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        key_debounce_fsm #(
            .DEB_CYC  (DEB_CYC),
            .LONG_CYC (LONG_CYC),
            .REP_CYC  (REP_CYC)
        ) u_key (
            .clk_i     (clk),
            .rst_i     (rst),
            .key_n_i   (key[i]),
            .level_o   (key_level[i]),
            .press_o   (press_pulse[i]),
            .release_o (release_pulse[i]),
            .long_o    (long_pulse[i]),
            .state_o   (key_state_unused[i])
        );
    end

endmodule
